writeback_multi: RTL and testbench

// Final pipeline stage for the multi-issue core: a LANES-wide generalisation of the single-lane writeback stage.

---
 rtl/writeback_multi.sv | 141 ++++++++++++++
 tb/tb_writeback_multi.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_multi.sv
// Multi-issue writeback stage: registers one commit bundle, drives LANES regfile
// write ports with youngest-writer-wins arbitration, counts commits, latches a sticky trap.
module writeback_multi #(
    parameter int LANES     = 2,
    parameter int DATA_W    = 32,
    parameter int REG_IDX_W = 5,
    parameter int CNT_W     = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall_i,
    input  logic                         flush_i,
    output logic                         stall_o,
    input  logic [LANES-1:0]             in_valid,
    input  logic [LANES-1:0]             in_we,
    input  logic [LANES*REG_IDX_W-1:0]   in_rd,
    input  logic [LANES*DATA_W-1:0]      in_data,
    input  logic [LANES*32-1:0]          in_pc,
    input  logic [LANES-1:0]             in_trap,
    output logic [LANES-1:0]             rf_we,
    output logic [LANES*REG_IDX_W-1:0]   rf_idx,
    output logic [LANES*DATA_W-1:0]      rf_data,
    output logic [LANES-1:0]             cmt_valid,
    output logic [LANES*32-1:0]          cmt_pc,
    output logic                         trap,
    output logic [7:0]                   trap_code,
    output logic [31:0]                  trap_pc,
    output logic [CNT_W-1:0]             cycle_cnt,
    output logic [CNT_W-1:0]             instr_cnt
);

    logic [LANES-1:0]                 v_q, we_q, tr_q;
    logic [LANES-1:0][REG_IDX_W-1:0]  rd_q;
    logic [LANES-1:0][DATA_W-1:0]     data_q;
    logic [LANES-1:0][31:0]           pc_q;

    logic [LANES-1:0]                 cmt_valid_q;
    logic [LANES-1:0][31:0]           cmt_pc_q;
    logic                             trap_q, trap_d;
    logic [7:0]                       code_q, code_d;
    logic [31:0]                      tpc_q, tpc_d;
    logic [CNT_W-1:0]                 cyc_q, cyc_d, instr_q, instr_d;

    logic [LANES-1:0]                 eff;
    logic                             older_trap;
    logic                             wr_ok;
    logic [CNT_W-1:0]                 pop;

    assign stall_o   = stall_i;
    assign rf_idx    = rd_q;
    assign rf_data   = data_q;
    assign cmt_valid = cmt_valid_q;
    assign cmt_pc    = cmt_pc_q;
    assign trap      = trap_q;
    assign trap_code = code_q;
    assign trap_pc   = tpc_q;
    assign cycle_cnt = cyc_q;
    assign instr_cnt = instr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= '0;
            we_q   <= '0;
            tr_q   <= '0;
            rd_q   <= '0;
            data_q <= '0;
            pc_q   <= '0;
        end else if (flush_i) begin
            v_q <= '0;
        end else if (!stall_i) begin
            v_q    <= in_valid;
            we_q   <= in_we;
            tr_q   <= in_trap;
            rd_q   <= in_rd;
            data_q <= in_data;
            pc_q   <= in_pc;
        end
    end

    // A valid trap in an older lane squashes every younger lane of the bundle.
    always_comb begin
        eff        = '0;
        older_trap = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            eff[i]     = v_q[i] & ~stall_i & ~trap_q & ~older_trap;
            older_trap = older_trap | (tr_q[i] & v_q[i]);
        end
    end

    always_comb begin
        rf_we = '0;
        wr_ok = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            wr_ok = eff[i] & we_q[i] & (rd_q[i] != '0);
            for (int j = i + 1; j < LANES; j++) begin
                if (eff[j] && we_q[j] && (rd_q[j] == rd_q[i]))
                    wr_ok = 1'b0;
            end
            rf_we[i] = wr_ok;
        end
    end

    // Scan from the top so the lowest trapping lane is the one that sticks.
    always_comb begin
        trap_d = trap_q;
        code_d = code_q;
        tpc_d  = tpc_q;
        pop    = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            pop = pop + CNT_W'(eff[i]);
            if (eff[i] && tr_q[i]) begin
                trap_d = 1'b1;
                code_d = data_q[i][7:0];
                tpc_d  = pc_q[i];
            end
        end
        instr_d = instr_q + pop;
        cyc_d   = trap_q ? cyc_q : cyc_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmt_valid_q <= '0;
            cmt_pc_q    <= '0;
            trap_q      <= 1'b0;
            code_q      <= '0;
            tpc_q       <= '0;
            cyc_q       <= '0;
            instr_q     <= '0;
        end else begin
            cmt_valid_q <= eff;
            cmt_pc_q    <= pc_q;
            trap_q      <= trap_d;
            code_q      <= code_d;
            tpc_q       <= tpc_d;
            cyc_q       <= cyc_d;
            instr_q     <= instr_d;
        end
    end

endmodule

// File: tb/tb_writeback_multi.sv
// Directed bench for writeback_multi: a per-cycle vector table plus hand-written
// trap, reset and counter-wrap sequences; a CNT_W=4 copy covers counter wrap.
module tb_writeback_multi;

    logic        clk = 1'b0;
    logic        rst, stall_i, flush_i;
    logic [1:0]  in_valid, in_we, in_trap;
    logic [9:0]  in_rd;
    logic [63:0] in_data, in_pc;

    logic        stall_o, trap;
    logic [1:0]  rf_we, cmt_valid;
    logic [9:0]  rf_idx;
    logic [63:0] rf_data, cmt_pc;
    logic [7:0]  trap_code;
    logic [31:0] trap_pc;
    logic [63:0] cycle_cnt, instr_cnt;

    logic        s_stall_o, s_trap;
    logic [1:0]  s_rf_we, s_cmt_valid;
    logic [9:0]  s_rf_idx;
    logic [63:0] s_rf_data, s_cmt_pc;
    logic [7:0]  s_trap_code;
    logic [31:0] s_trap_pc;
    logic [3:0]  s_cycle_cnt, s_instr_cnt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    writeback_multi u_dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .stall_o(stall_o),
        .in_valid(in_valid), .in_we(in_we), .in_rd(in_rd), .in_data(in_data),
        .in_pc(in_pc), .in_trap(in_trap), .rf_we(rf_we), .rf_idx(rf_idx),
        .rf_data(rf_data), .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .trap(trap),
        .trap_code(trap_code), .trap_pc(trap_pc), .cycle_cnt(cycle_cnt),
        .instr_cnt(instr_cnt)
    );

    writeback_multi #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .stall_o(s_stall_o),
        .in_valid(in_valid), .in_we(in_we), .in_rd(in_rd), .in_data(in_data),
        .in_pc(in_pc), .in_trap(in_trap), .rf_we(s_rf_we), .rf_idx(s_rf_idx),
        .rf_data(s_rf_data), .cmt_valid(s_cmt_valid), .cmt_pc(s_cmt_pc), .trap(s_trap),
        .trap_code(s_trap_code), .trap_pc(s_trap_pc), .cycle_cnt(s_cycle_cnt),
        .instr_cnt(s_instr_cnt)
    );

    typedef struct {
        logic        st, fl;
        logic [1:0]  v, we, tr;
        logic [4:0]  r0, r1;
        logic [31:0] d0, d1, p0, p1;
        logic [1:0]  e_we, e_cmt;
        logic [63:0] e_instr;
        logic        c_d;
        logic [4:0]  e_idx0;
        logic [31:0] e_d1;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drv(input logic st, input logic fl, input logic [1:0] v, input logic [1:0] we,
                       input logic [1:0] tr, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] p0, input logic [31:0] p1);
        stall_i  = st;
        flush_i  = fl;
        in_valid = v;
        in_we    = we;
        in_trap  = tr;
        in_rd    = {r1, r0};
        in_data  = {d1, d0};
        in_pc    = {p1, p0};
    endtask

    // One cycle: drive at negedge, sample 2ns later, well clear of the posedge.
    task automatic step(input logic r, input logic st, input logic fl, input logic [1:0] v,
                        input logic [1:0] we, input logic [1:0] tr, input logic [4:0] r0,
                        input logic [4:0] r1, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] p0, input logic [31:0] p1);
        @(negedge clk);
        rst = r;
        drv(st, fl, v, we, tr, r0, r1, d0, d1, p0, p1);
        #2;
    endtask

    task automatic idle(input logic r);
        step(r, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        tbl[0]  = '{1'b0,1'b0,2'b11,2'b11,2'b00,5'd3,5'd5,32'hA,32'hB,32'h100,32'h104, 2'b00,2'b00,64'd0, 1'b0,5'd0,32'h0};
        tbl[1]  = '{1'b0,1'b0,2'b00,2'b00,2'b00,5'd0,5'd0,32'h0,32'h0,32'h0,32'h0,     2'b11,2'b00,64'd0, 1'b1,5'd3,32'hB};
        tbl[2]  = '{1'b0,1'b0,2'b11,2'b11,2'b00,5'd7,5'd7,32'h11,32'h22,32'h0,32'h0,   2'b00,2'b11,64'd2, 1'b0,5'd0,32'h0};
        tbl[3]  = '{1'b0,1'b0,2'b01,2'b01,2'b00,5'd0,5'd0,32'h0,32'h0,32'h0,32'h0,     2'b10,2'b00,64'd2, 1'b1,5'd7,32'h22};
        tbl[4]  = '{1'b0,1'b0,2'b11,2'b11,2'b00,5'd1,5'd2,32'h33,32'h44,32'h0,32'h0,   2'b00,2'b11,64'd4, 1'b0,5'd0,32'h0};
        tbl[5]  = '{1'b1,1'b0,2'b00,2'b00,2'b00,5'd0,5'd0,32'h0,32'h0,32'h0,32'h0,     2'b00,2'b01,64'd5, 1'b1,5'd1,32'h44};
        tbl[6]  = '{1'b1,1'b0,2'b00,2'b00,2'b00,5'd0,5'd0,32'h0,32'h0,32'h0,32'h0,     2'b00,2'b00,64'd5, 1'b1,5'd1,32'h44};
        tbl[7]  = '{1'b1,1'b0,2'b00,2'b00,2'b00,5'd0,5'd0,32'h0,32'h0,32'h0,32'h0,     2'b00,2'b00,64'd5, 1'b1,5'd1,32'h44};
        tbl[8]  = '{1'b0,1'b0,2'b00,2'b00,2'b00,5'd0,5'd0,32'h0,32'h0,32'h0,32'h0,     2'b11,2'b00,64'd5, 1'b1,5'd1,32'h44};
        tbl[9]  = '{1'b0,1'b0,2'b11,2'b11,2'b00,5'd8,5'd9,32'h0,32'h55,32'h0,32'h0,    2'b00,2'b11,64'd7, 1'b0,5'd0,32'h0};
        tbl[10] = '{1'b1,1'b0,2'b00,2'b00,2'b00,5'd0,5'd0,32'h0,32'h0,32'h0,32'h0,     2'b00,2'b00,64'd7, 1'b1,5'd8,32'h55};
        tbl[11] = '{1'b1,1'b1,2'b00,2'b00,2'b00,5'd0,5'd0,32'h0,32'h0,32'h0,32'h0,     2'b00,2'b00,64'd7, 1'b0,5'd0,32'h0};
        tbl[12] = '{1'b0,1'b0,2'b00,2'b00,2'b00,5'd0,5'd0,32'h0,32'h0,32'h0,32'h0,     2'b00,2'b00,64'd7, 1'b0,5'd0,32'h0};
        tbl[13] = '{1'b0,1'b0,2'b00,2'b00,2'b00,5'd0,5'd0,32'h0,32'h0,32'h0,32'h0,     2'b00,2'b00,64'd7, 1'b0,5'd0,32'h0};

        rst = 1'b1;
        drv(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        idle(1'b1);
        chk("rst_cmt_valid", 64'(cmt_valid), 64'd0);
        chk("rst_trap", 64'(trap), 64'd0);
        chk("rst_instr", instr_cnt, 64'd0);
        chk("rst_cycle", cycle_cnt, 64'd0);
        chk("rst_rf_we", 64'(rf_we), 64'd0);

        // Bundles, WAW, x0, stall and flush: one table row per cycle.
        for (int i = 0; i < 14; i++) begin
            step(1'b0, tbl[i].st, tbl[i].fl, tbl[i].v, tbl[i].we, tbl[i].tr, tbl[i].r0,
                 tbl[i].r1, tbl[i].d0, tbl[i].d1, tbl[i].p0, tbl[i].p1);
            chk($sformatf("row%0d_rf_we", i), 64'(rf_we), 64'(tbl[i].e_we));
            chk($sformatf("row%0d_cmt_valid", i), 64'(cmt_valid), 64'(tbl[i].e_cmt));
            chk($sformatf("row%0d_instr", i), instr_cnt, tbl[i].e_instr);
            chk($sformatf("row%0d_cycle", i), cycle_cnt, 64'(i));
            chk($sformatf("row%0d_stall_o", i), 64'(stall_o), 64'(tbl[i].st));
            if (tbl[i].c_d) begin
                chk($sformatf("row%0d_rf_idx0", i), 64'(rf_idx[4:0]), 64'(tbl[i].e_idx0));
                chk($sformatf("row%0d_rf_data1", i), 64'(rf_data[63:32]), 64'(tbl[i].e_d1));
            end
            if (i == 2) chk("row2_cmt_pc0", 64'(cmt_pc[31:0]), 64'h100);
        end

        // Lane 0 traps: lane 1 squashed, then everything freezes.
        step(1'b0, 1'b0, 1'b0, 2'b11, 2'b11, 2'b01, 5'd4, 5'd6, 32'h0, 32'h77,
             32'h1c000100, 32'h1c000104);
        chk("t5_cycle_pre", cycle_cnt, 64'd14);
        idle(1'b0);
        chk("t5_rf_we", 64'(rf_we), 64'b01);
        chk("t5_trap_pre", 64'(trap), 64'd0);
        step(1'b0, 1'b0, 1'b0, 2'b11, 2'b11, 2'b00, 5'd10, 5'd11, 32'h1, 32'h2, 32'h0, 32'h0);
        chk("t5_trap", 64'(trap), 64'd1);
        chk("t5_trap_code", 64'(trap_code), 64'h0);
        chk("t5_trap_pc", 64'(trap_pc), 64'h1c000100);
        chk("t5_instr", instr_cnt, 64'd8);
        chk("t5_cmt_valid", 64'(cmt_valid), 64'b01);
        chk("t5_cycle", cycle_cnt, 64'd16);
        idle(1'b0);
        chk("t5_rf_we_after", 64'(rf_we), 64'b00);
        chk("t5_cycle_frozen", cycle_cnt, 64'd16);
        idle(1'b0);
        chk("t5_cmt_after", 64'(cmt_valid), 64'b00);
        chk("t5_instr_after", instr_cnt, 64'd8);
        chk("t5_cycle_frozen2", cycle_cnt, 64'd16);
        chk("t5_trap_sticky", 64'(trap), 64'd1);

        // Reset clears the trap; then lane 1 traps with a nonzero code.
        idle(1'b1);
        step(1'b0, 1'b0, 1'b0, 2'b11, 2'b11, 2'b10, 5'd12, 5'd13, 32'h5, 32'h123456AB,
             32'h200, 32'h204);
        chk("rst2_trap", 64'(trap), 64'd0);
        chk("rst2_trap_pc", 64'(trap_pc), 64'd0);
        chk("rst2_instr", instr_cnt, 64'd0);
        chk("rst2_cycle", cycle_cnt, 64'd0);
        idle(1'b0);
        chk("l1_rf_we", 64'(rf_we), 64'b11);
        idle(1'b0);
        chk("l1_trap", 64'(trap), 64'd1);
        chk("l1_trap_code", 64'(trap_code), 64'hAB);
        chk("l1_trap_pc", 64'(trap_pc), 64'h204);
        chk("l1_instr", instr_cnt, 64'd2);
        chk("l1_cmt_valid", 64'(cmt_valid), 64'b11);

        // Counter wrap on the CNT_W=4 copy.
        idle(1'b1);
        for (int n = 0; n <= 17; n++) begin
            idle(1'b0);
            if (n >= 14) chk($sformatf("wrap%0d_cycle4", n), 64'(s_cycle_cnt), 64'(n % 16));
        end
        chk("wrap_cycle64", cycle_cnt, 64'd17);
        chk("wrap_instr4", 64'(s_instr_cnt), 64'd0);

        // Reset in the middle of live traffic.
        step(1'b0, 1'b0, 1'b0, 2'b11, 2'b11, 2'b00, 5'd1, 5'd2, 32'h9, 32'hA, 32'h300, 32'h304);
        step(1'b0, 1'b0, 1'b0, 2'b11, 2'b11, 2'b00, 5'd3, 5'd4, 32'hB, 32'hC, 32'h308, 32'h30c);
        chk("mr_rf_we", 64'(rf_we), 64'b11);
        step(1'b1, 1'b0, 1'b0, 2'b11, 2'b11, 2'b00, 5'd5, 5'd6, 32'hD, 32'hE, 32'h310, 32'h314);
        chk("mr_cmt_pre", 64'(cmt_valid), 64'b11);
        chk("mr_instr_pre", instr_cnt, 64'd2);
        step(1'b1, 1'b0, 1'b0, 2'b11, 2'b11, 2'b00, 5'd5, 5'd6, 32'hD, 32'hE, 32'h310, 32'h314);
        chk("mr_rf_we", 64'(rf_we), 64'b00);
        chk("mr_cmt_valid", 64'(cmt_valid), 64'b00);
        chk("mr_cmt_pc", cmt_pc, 64'h0);
        chk("mr_instr", instr_cnt, 64'd0);
        chk("mr_cycle", cycle_cnt, 64'd0);
        chk("mr_cycle4", 64'(s_cycle_cnt), 64'd0);
        chk("mr_trap", 64'(trap), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
